decode_stage_pipe: RTL

Parametrised, pipelined decode stage for the vector ASIP. Decodes one instruction per cycle into the execute control bundle (MemoryWrite, ExecuteOp, WriteRegFrom, OverwriteNZ, RegToWrite, Immediate, scalar/vector write enables) and holds the bundle in a registered ID/EX slot with valid/ready handshakes on both sides. A per-register scoreboard for the scalar and vector files stalls decode on RAW/WAW hazards. A flush input squashes the slot.

---
 rtl/decode_pkg.sv | 68 ++++++
 rtl/decoder_core.sv | 67 ++++++
 rtl/decode_stage_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared opcode, control-bundle types and decode helpers for the vector ASIP decode stage.
package decode_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_AND   = 3'd3,
        OP_OR    = 3'd4,
        OP_MOVI  = 3'd5,
        OP_LOAD  = 3'd6,
        OP_STORE = 3'd7
    } opcode_e;

    localparam logic [1:0] WRF_ALU = 2'b00;
    localparam logic [1:0] WRF_MEM = 2'b01;
    localparam logic [1:0] WRF_IMM = 2'b10;

    // Width-independent part of the execute bundle; rd and immediate travel alongside.
    typedef struct packed {
        logic       mem_write;
        logic [2:0] exop;
        logic [1:0] wrf;
        logic       overwrite_nz;
        logic       wen_sc;
        logic       wen_vec;
    } ctrl_bundle_t;

    function automatic opcode_e op_base(input logic [OPC_W-1:0] opc);
        return opcode_e'(opc[2:0]);
    endfunction

    function automatic logic op_is_vec(input logic [OPC_W-1:0] opc);
        return opc[3];
    endfunction

    function automatic ctrl_bundle_t decode_ctrl(input logic [OPC_W-1:0] opc);
        ctrl_bundle_t c;
        logic         vec;
        c   = '0;
        vec = op_is_vec(opc);
        case (op_base(opc))
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                c.exop         = opc[2:0];
                c.wrf          = WRF_ALU;
                c.overwrite_nz = !vec;
                c.wen_sc       = !vec;
                c.wen_vec      = vec;
            end
            OP_MOVI: begin
                c.wrf     = WRF_IMM;
                c.wen_sc  = !vec;
                c.wen_vec = vec;
            end
            OP_LOAD: begin
                c.wrf     = WRF_MEM;
                c.wen_sc  = !vec;
                c.wen_vec = vec;
            end
            OP_STORE: c.mem_write = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational instruction decode: control bundle plus one-hot read/write masks
// for the scalar and vector register files.
module decoder_core
    import decode_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 4,
    parameter int IMM_W   = 8
) (
    input  logic [INSTR_W-1:0]      instr_i,
    output ctrl_bundle_t            ctrl_o,
    output logic [REG_AW-1:0]       rd_o,
    output logic [IMM_W-1:0]        imm_o,
    output logic [(1<<REG_AW)-1:0]  rmask_sc_o,
    output logic [(1<<REG_AW)-1:0]  rmask_vec_o,
    output logic [(1<<REG_AW)-1:0]  wmask_sc_o,
    output logic [(1<<REG_AW)-1:0]  wmask_vec_o
);
    localparam int NREG = 1 << REG_AW;

    logic [OPC_W-1:0]  opc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [NREG-1:0]   oh_rd;
    logic [NREG-1:0]   oh_rs1;
    logic [NREG-1:0]   oh_rs2;
    logic              vec;

    assign opc    = instr_i[INSTR_W-1 -: OPC_W];
    assign rd_o   = instr_i[INSTR_W-OPC_W-1 -: REG_AW];
    assign rs1    = instr_i[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
    assign rs2    = instr_i[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];
    assign imm_o  = instr_i[IMM_W-1:0];

    assign oh_rd  = NREG'(1) << rd_o;
    assign oh_rs1 = NREG'(1) << rs1;
    assign oh_rs2 = NREG'(1) << rs2;

    assign vec    = op_is_vec(opc);
    assign ctrl_o = decode_ctrl(opc);

    // Memory addresses always come from the scalar file; store data follows the vector flag.
    always_comb begin
        rmask_sc_o  = '0;
        rmask_vec_o = '0;
        case (op_base(opc))
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                if (vec) rmask_vec_o = oh_rs1 | oh_rs2;
                else     rmask_sc_o  = oh_rs1 | oh_rs2;
            end
            OP_LOAD: rmask_sc_o = oh_rs1;
            OP_STORE: begin
                if (vec) begin
                    rmask_sc_o  = oh_rs1;
                    rmask_vec_o = oh_rd;
                end else begin
                    rmask_sc_o  = oh_rs1 | oh_rd;
                end
            end
            default: ;
        endcase
    end

    assign wmask_sc_o  = ctrl_o.wen_sc  ? oh_rd : '0;
    assign wmask_vec_o = ctrl_o.wen_vec ? oh_rd : '0;

endmodule

// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: registered ID/EX slot with valid/ready handshakes and a
// per-register scoreboard for the scalar and vector files.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 4,
    parameter int IMM_W   = 8,
    parameter int EXOP_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                MemoryWrite,
    output logic [EXOP_W-1:0]   ExecuteOp,
    output logic [1:0]          WriteRegFrom,
    output logic                OverwriteNZ,
    output logic [REG_AW-1:0]   RegToWrite,
    output logic [IMM_W-1:0]    Immediate,
    output logic                RegWriteEnSc,
    output logic                RegWriteEnVec,
    input  logic                wb_sc_valid,
    input  logic [REG_AW-1:0]   wb_sc_addr,
    input  logic                wb_vec_valid,
    input  logic [REG_AW-1:0]   wb_vec_addr
);
    localparam int NREG = 1 << REG_AW;

    ctrl_bundle_t      dec_ctrl;
    logic [REG_AW-1:0] dec_rd;
    logic [IMM_W-1:0]  dec_imm;
    logic [NREG-1:0]   rmask_sc, rmask_vec, wmask_sc, wmask_vec;

    logic              valid_q, valid_d;
    ctrl_bundle_t      ctrl_q, ctrl_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [IMM_W-1:0]  imm_q, imm_d;
    logic [NREG-1:0]   pend_sc_q, pend_sc_d;
    logic [NREG-1:0]   pend_vec_q, pend_vec_d;

    logic [NREG-1:0]   slot_sc, slot_vec;
    logic              hazard, load, issue;

    decoder_core #(
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW),
        .IMM_W   (IMM_W)
    ) u_dec (
        .instr_i     (instruction),
        .ctrl_o      (dec_ctrl),
        .rd_o        (dec_rd),
        .imm_o       (dec_imm),
        .rmask_sc_o  (rmask_sc),
        .rmask_vec_o (rmask_vec),
        .wmask_sc_o  (wmask_sc),
        .wmask_vec_o (wmask_vec)
    );

    assign slot_sc  = (valid_q && ctrl_q.wen_sc)  ? (NREG'(1) << rd_q) : '0;
    assign slot_vec = (valid_q && ctrl_q.wen_vec) ? (NREG'(1) << rd_q) : '0;

    // Registered scoreboard only: a retirement is seen by the hazard check one cycle later.
    assign hazard = |((rmask_sc  | wmask_sc)  & (pend_sc_q  | slot_sc)) ||
                    |((rmask_vec | wmask_vec) & (pend_vec_q | slot_vec));

    assign in_ready = !flush && !hazard && (!valid_q || out_ready);
    assign load     = in_valid && in_ready;
    assign issue    = valid_q && out_ready && !flush;

    always_comb begin
        valid_d = !flush && (load || (valid_q && !out_ready));
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        if (load) begin
            ctrl_d = dec_ctrl;
            rd_d   = dec_rd;
            imm_d  = dec_imm;
        end
    end

    // Set is applied after clear so a same-cycle issue on a retiring register keeps it pending.
    always_comb begin
        pend_sc_d  = pend_sc_q;
        pend_vec_d = pend_vec_q;
        if (wb_sc_valid)  pend_sc_d  = pend_sc_d  & ~(NREG'(1) << wb_sc_addr);
        if (wb_vec_valid) pend_vec_d = pend_vec_d & ~(NREG'(1) << wb_vec_addr);
        if (issue) begin
            pend_sc_d  = pend_sc_d  | slot_sc;
            pend_vec_d = pend_vec_d | slot_vec;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            pend_sc_q  <= '0;
            pend_vec_q <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            pend_sc_q  <= pend_sc_d;
            pend_vec_q <= pend_vec_d;
        end
    end

    assign out_valid     = valid_q;
    assign MemoryWrite   = ctrl_q.mem_write;
    assign ExecuteOp     = EXOP_W'(ctrl_q.exop);
    assign WriteRegFrom  = ctrl_q.wrf;
    assign OverwriteNZ   = ctrl_q.overwrite_nz;
    assign RegToWrite    = rd_q;
    assign Immediate     = imm_q;
    assign RegWriteEnSc  = ctrl_q.wen_sc;
    assign RegWriteEnVec = ctrl_q.wen_vec;

endmodule
